// File: rtl/risc_pkg.sv
// risc_pkg: shared constants for the RISC operand-fetch slice.
//   RISC_DATA_W / RISC_ADDR_W / RISC_STALL_W : default widths
//   RISC_NREG                                : register count for the default width
//   R0                                       : hard-wired zero register index
package risc_pkg;
  localparam int RISC_DATA_W  = 32;
  localparam int RISC_ADDR_W  = 5;
  localparam int RISC_STALL_W = 16;
  localparam int RISC_NREG    = 2**RISC_ADDR_W;
  localparam int R0           = 0;
endpackage

// File: rtl/risc_scoreboard.sv
// risc_scoreboard: one pending bit per register for in-flight destination
// writes, with three lookups (two sources, one destination).
//   CLK, reset            : clock, synchronous active-high reset
//   wb_RW, wb_DA          : writeback clears the pending bit of wb_DA
//   set_en, set_DA        : issue of a writing instruction sets set_DA
//   look_a/look_b/look_d  : addresses to look up
//   busy_a/busy_b/busy_d  : pending and NOT being written back this edge
module risc_scoreboard
  import risc_pkg::*;
#(
  parameter int ADDR_W = RISC_ADDR_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              wb_RW,
  input  logic [ADDR_W-1:0] wb_DA,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_DA,
  input  logic [ADDR_W-1:0] look_a,
  input  logic [ADDR_W-1:0] look_b,
  input  logic [ADDR_W-1:0] look_d,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_d
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] W_R0 = ADDR_W'(R0);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  logic            w_clr_a, w_clr_b, w_clr_d;

  // A writeback landing this edge resolves the hazard, so it masks the bit.
  assign w_clr_a = wb_RW && (wb_DA == look_a) && (look_a != W_R0);
  assign w_clr_b = wb_RW && (wb_DA == look_b) && (look_b != W_R0);
  assign w_clr_d = wb_RW && (wb_DA == look_d) && (look_d != W_R0);

  assign busy_a = r_pend[look_a] && !w_clr_a;
  assign busy_b = r_pend[look_b] && !w_clr_b;
  assign busy_d = r_pend[look_d] && !w_clr_d;

  // Clear first, then set: a same-cycle set to the same register wins,
  // since the newly issued write is still outstanding.
  always_comb begin
    w_pend_nxt = r_pend;
    if (wb_RW && wb_DA != W_R0) w_pend_nxt[wb_DA] = 1'b0;
    if (set_en && set_DA != W_R0) w_pend_nxt[set_DA] = 1'b1;
    w_pend_nxt[R0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (reset) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end
endmodule

// File: rtl/risc_operand_fetch.sv
// risc_operand_fetch: read side of the register file. Drives file read
// addresses, forwards same-cycle writeback data, stalls decode on RAW/WAW
// hazards and presents registered operands to execute (valid/ready).
//   CLK, reset                    : clock, synchronous active-high reset
//   in_valid/in_ready             : decode handshake
//   in_AA, in_BA, in_use_a/b      : sources and whether they are read
//   in_DA, in_RW                  : destination and write enable
//   rf_AA, rf_BA, rf_A/B_Data     : register file read ports
//   wb_RW, wb_DA, wb_D_Data       : writeback (same as file write port)
//   out_valid/out_ready           : execute handshake
//   out_A, out_B, out_DA, out_RW  : registered operands and destination
//   stall_cycles                  : saturating count of stalled cycles
module risc_operand_fetch
  import risc_pkg::*;
#(
  parameter int DATA_W  = RISC_DATA_W,
  parameter int ADDR_W  = RISC_ADDR_W,
  parameter int STALL_W = RISC_STALL_W
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_AA,
  input  logic [ADDR_W-1:0]  in_BA,
  input  logic               in_use_a,
  input  logic               in_use_b,
  input  logic [ADDR_W-1:0]  in_DA,
  input  logic               in_RW,
  output logic [ADDR_W-1:0]  rf_AA,
  output logic [ADDR_W-1:0]  rf_BA,
  input  logic [DATA_W-1:0]  rf_A_Data,
  input  logic [DATA_W-1:0]  rf_B_Data,
  input  logic               wb_RW,
  input  logic [ADDR_W-1:0]  wb_DA,
  input  logic [DATA_W-1:0]  wb_D_Data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_A,
  output logic [DATA_W-1:0]  out_B,
  output logic [ADDR_W-1:0]  out_DA,
  output logic               out_RW,
  output logic [STALL_W-1:0] stall_cycles
);
  localparam logic [ADDR_W-1:0] W_R0 = ADDR_W'(R0);

  logic               w_busy_a, w_busy_b, w_busy_d;
  logic               w_raw_a, w_raw_b, w_waw, w_hazard;
  logic               w_slot_free, w_issue;
  logic               w_fwd_a, w_fwd_b;
  logic [DATA_W-1:0]  w_op_a, w_op_b;

  logic               r_valid;
  logic [DATA_W-1:0]  r_a, r_b;
  logic [ADDR_W-1:0]  r_da;
  logic               r_rw;
  logic [STALL_W-1:0] r_stall;

  assign rf_AA = in_AA;
  assign rf_BA = in_BA;

  risc_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .CLK    (CLK),
    .reset  (reset),
    .wb_RW  (wb_RW),
    .wb_DA  (wb_DA),
    .set_en (w_issue && in_RW),
    .set_DA (in_DA),
    .look_a (in_AA),
    .look_b (in_BA),
    .look_d (in_DA),
    .busy_a (w_busy_a),
    .busy_b (w_busy_b),
    .busy_d (w_busy_d)
  );

  assign w_raw_a     = in_use_a && w_busy_a;
  assign w_raw_b     = in_use_b && w_busy_b;
  assign w_waw       = in_RW && (in_DA != W_R0) && w_busy_d;
  assign w_hazard    = in_valid && (w_raw_a || w_raw_b || w_waw);
  assign w_slot_free = !r_valid || out_ready;
  assign in_ready    = !w_hazard && w_slot_free;
  assign w_issue     = in_valid && in_ready;

  // The file write lands on the same edge that captures operands, so the
  // file still shows the old value; take the writeback data instead.
  // R0 is never forwarded.
  assign w_fwd_a = wb_RW && (wb_DA == in_AA) && (in_AA != W_R0);
  assign w_fwd_b = wb_RW && (wb_DA == in_BA) && (in_BA != W_R0);
  assign w_op_a  = w_fwd_a ? wb_D_Data : rf_A_Data;
  assign w_op_b  = w_fwd_b ? wb_D_Data : rf_B_Data;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_da    <= '0;
      r_rw    <= 1'b0;
    end else if (w_issue) begin
      r_valid <= 1'b1;
      r_a     <= w_op_a;
      r_b     <= w_op_b;
      r_da    <= in_DA;
      r_rw    <= in_RW;
    end else if (out_ready) begin
      // Data registers hold; only the valid drops once consumed.
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset)
      r_stall <= '0;
    else if (in_valid && !in_ready && (r_stall != {STALL_W{1'b1}}))
      r_stall <= r_stall + 1'b1;
  end

  assign out_valid    = r_valid;
  assign out_A        = r_a;
  assign out_B        = r_b;
  assign out_DA       = r_da;
  assign out_RW       = r_rw;
  assign stall_cycles = r_stall;
endmodule

// File: tb/tb_risc_operand_fetch.sv
module tb_risc_operand_fetch;
  logic        CLK = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_AA, in_BA, in_DA;
  logic        in_use_a, in_use_b, in_RW;
  logic [4:0]  rf_AA, rf_BA;
  logic [31:0] rf_A_Data, rf_B_Data;
  logic        wb_RW;
  logic [4:0]  wb_DA;
  logic [31:0] wb_D_Data;
  logic        out_valid, out_ready;
  logic [31:0] out_A, out_B;
  logic [4:0]  out_DA;
  logic        out_RW;
  logic [15:0] stall_cycles;

  always #5 CLK = ~CLK;

  risc_operand_fetch dut (
    .CLK(CLK), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_AA(in_AA), .in_BA(in_BA), .in_use_a(in_use_a), .in_use_b(in_use_b),
    .in_DA(in_DA), .in_RW(in_RW),
    .rf_AA(rf_AA), .rf_BA(rf_BA), .rf_A_Data(rf_A_Data), .rf_B_Data(rf_B_Data),
    .wb_RW(wb_RW), .wb_DA(wb_DA), .wb_D_Data(wb_D_Data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_A(out_A), .out_B(out_B), .out_DA(out_DA), .out_RW(out_RW),
    .stall_cycles(stall_cycles)
  );

  // Register file model: combinational read, write on the clock edge, R0 fixed.
  logic [31:0] rf [32];
  assign rf_A_Data = rf[rf_AA];
  assign rf_B_Data = rf[rf_BA];
  always @(posedge CLK)
    if (wb_RW && wb_DA != 5'd0) rf[wb_DA] <= wb_D_Data;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [4:0]  da;
    logic        rw;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_pend = '0;
  logic        m_ov   = 1'b0;
  int          m_stall = 0;

  // Reference model, evaluated mid-cycle against the inputs about to be
  // clocked in.
  always @(negedge CLK) begin
    logic ca, cb, cd, hz, rdy, iss;
    exp_t e;
    ca  = wb_RW && wb_DA == in_AA && in_AA != 5'd0;
    cb  = wb_RW && wb_DA == in_BA && in_BA != 5'd0;
    cd  = wb_RW && wb_DA == in_DA && in_DA != 5'd0;
    hz  = in_valid && ((in_use_a && m_pend[in_AA] && !ca) ||
                       (in_use_b && m_pend[in_BA] && !cb) ||
                       (in_RW && in_DA != 5'd0 && m_pend[in_DA] && !cd));
    rdy = !hz && (!m_ov || out_ready);
    iss = in_valid && rdy;
    if (in_valid) chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_ov);
    chk("stall", stall_cycles, m_stall[15:0]);
    if (m_ov) begin
      if (q.size() == 0) chk("q_empty", 1, 0);
      else begin
        chk("out_A", out_A, q[0].a);
        chk("out_B", out_B, q[0].b);
        chk("out_DA", out_DA, q[0].da);
        chk("out_RW", out_RW, q[0].rw);
        if (out_ready) void'(q.pop_front());
      end
    end
    if (reset) begin
      q.delete();
      m_ov = 1'b0; m_pend = '0; m_stall = 0;
    end else begin
      if (in_valid && !rdy && m_stall < 65535) m_stall++;
      if (iss) begin
        e.a  = ca ? wb_D_Data : rf[in_AA];
        e.b  = cb ? wb_D_Data : rf[in_BA];
        e.da = in_DA;
        e.rw = in_RW;
        q.push_back(e);
      end
      m_ov = iss ? 1'b1 : (out_ready ? 1'b0 : m_ov);
      if (wb_RW && wb_DA != 5'd0) m_pend[wb_DA] = 1'b0;
      if (iss && in_RW && in_DA != 5'd0) m_pend[in_DA] = 1'b1;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] aa, input logic [4:0] ba,
                     input logic ua, input logic ub, input logic [4:0] da, input logic rw);
    in_valid = v; in_AA = aa; in_BA = ba; in_use_a = ua; in_use_b = ub;
    in_DA = da; in_RW = rw;
  endtask

  task automatic wb(input logic en, input logic [4:0] da, input logic [31:0] d);
    wb_RW = en; wb_DA = da; wb_D_Data = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = i;
    reset = 1'b1; out_ready = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_ov", out_valid, 0);
    chk("rst_A", out_A, 0);
    chk("rst_stall", stall_cycles, 0);

    // Basic issue
    drv(1, 3, 4, 1, 1, 5, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("iss_ov", out_valid, 1);
    chk("iss_A", out_A, 3);
    chk("iss_B", out_B, 4);
    chk("iss_DA", out_DA, 5);

    // RAW on R5 until writeback, which is forwarded
    drv(1, 5, 0, 1, 0, 0, 0);
    repeat (3) tick();
    chk("raw_stall", stall_cycles, 3);
    wb(1, 5, 32'hDEADBEEF); #1;
    chk("fwd_rdy", in_ready, 1);
    tick();
    wb(0, 0, 0); drv(0, 0, 0, 0, 0, 0, 0);
    chk("fwd_A", out_A, 32'hDEADBEEF);

    // WAW on R6; same-cycle writeback lets it issue and pend stays set
    drv(1, 0, 0, 0, 0, 6, 1);
    tick();
    repeat (2) tick();
    wb(1, 6, 32'h600D); #1;
    chk("waw_rdy", in_ready, 1);
    tick();
    wb(0, 0, 0);
    drv(1, 6, 0, 1, 0, 0, 0);
    tick();
    chk("set_wins", in_ready, 0);
    tick();
    wb(1, 6, 32'h12345678);
    tick();
    wb(0, 0, 0); drv(0, 0, 0, 0, 0, 0, 0);
    chk("waw_A", out_A, 32'h12345678);
    chk("waw_stall", stall_cycles, 7);

    // Backpressure
    drv(1, 1, 2, 1, 1, 8, 1);
    tick();
    out_ready = 1'b0;
    drv(1, 3, 0, 1, 0, 2, 1);
    repeat (3) tick();
    chk("bp_stall", stall_cycles, 10);
    chk("bp_DA", out_DA, 8);
    chk("bp_rdy", in_ready, 0);
    out_ready = 1'b1; #1;
    chk("bp_rel", in_ready, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("bp_DA2", out_DA, 2);

    // R0 destination never pends; R0 source never forwards
    drv(1, 0, 0, 0, 0, 0, 1); #1;
    chk("r0_dst", in_ready, 1);
    tick();
    drv(1, 0, 0, 1, 0, 3, 0);
    wb(1, 0, 32'hFFFFFFFF); #1;
    chk("r0_src", in_ready, 1);
    tick();
    wb(0, 0, 0); drv(0, 0, 0, 0, 0, 0, 0);
    chk("r0_A", out_A, 0);

    // Reset mid-operation
    drv(1, 0, 0, 0, 0, 7, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_ov", out_valid, 1);
    reset = 1'b1; out_ready = 1'b0;
    drv(1, 7, 0, 1, 0, 0, 0);
    tick();
    reset = 1'b0; out_ready = 1'b1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_stall", stall_cycles, 0);
    chk("r7_rdy", in_ready, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("r7_ov", out_valid, 1);

    // Random mix against the model
    for (int i = 0; i < 300; i++) begin
      drv(($urandom % 4) != 0, 5'($urandom % 8), 5'($urandom % 8),
          1'($urandom), 1'($urandom), 5'($urandom % 8), 1'($urandom));
      wb(($urandom % 3) == 0, 5'($urandom % 8), $urandom);
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    out_ready = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/risc_operand_fetch.md
Name: risc_operand_fetch

Overview:
- Read-side partner of the RISC register file. Accepts decoded instructions from decode and drives the file's read addresses.
- Forwards writeback data when a source register is written in the same cycle, and tracks in-flight destination writes in a scoreboard.
- Stalls decode on RAW and WAW hazards and presents registered operands to execute over a valid/ready handshake.

Parameters:
- DATA_W, 32, operand/register width.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers.
- STALL_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  issue accepted this cycle.
- in_AA, in_BA  in  ADDR_W  source register addresses.
- in_use_a, in_use_b  in  1  source A / B actually read.
- in_DA  in  ADDR_W  destination register.
- in_RW  in  1  instruction writes the register file.
- rf_AA, rf_BA  out  ADDR_W  to register file read ports.
- rf_A_Data, rf_B_Data  in  DATA_W  register file read data (combinational).
- wb_RW  in  1  writeback write enable (same signal that drives the file's RW).
- wb_DA  in  ADDR_W  writeback destination.
- wb_D_Data  in  DATA_W  writeback data.
- out_valid  out  1  operands valid to execute.
- out_ready  in  1  execute accepts.
- out_A, out_B  out  DATA_W  resolved operands.
- out_DA  out  ADDR_W  registered destination.
- out_RW  out  1  registered write enable.
- stall_cycles  out  STALL_W  saturating count of hazard stalls.

Behaviour:
- rf_AA = in_AA and rf_BA = in_BA, combinational pass-through.
- Scoreboard: pend[NREG-1:0]. pend[0] is constantly 0.
- wb_clr(r) = wb_RW && wb_DA==r && r!=0.
- RAW hazard on A = in_use_a && pend[in_AA] && !wb_clr(in_AA). Same rule for B.
- WAW hazard = in_RW && in_DA!=0 && pend[in_DA] && !wb_clr(in_DA).
- hazard = in_valid && (rawA || rawB || waw).
- slot_free = !out_valid || out_ready.
- in_ready = !hazard && slot_free. It is combinational and meaningful only while in_valid.
- issue = in_valid && in_ready.
- Operand select for A: if wb_clr(in_AA), use wb_D_Data (forward, because the file write lands this edge). Otherwise use rf_A_Data. B uses the same rule. A source of R0 always takes rf data.
- On issue, the output register loads out_A, out_B, out_DA, out_RW and sets out_valid=1. Latency is 1 cycle from issue to out_valid.
- If out_valid && out_ready && !issue: out_valid<=0, data registers hold.
- If out_valid && !out_ready: all output registers hold. Backpressure blocks issue.
- Scoreboard update each edge: clear pend[wb_DA] if wb_RW && wb_DA!=0. Then set pend[in_DA] if issue && in_RW && in_DA!=0. The set wins when both target the same register in the same cycle.
- A clear for a register that is not pending is ignored; no error is raised.
- stall_cycles increments by 1 on every cycle with in_valid && !in_ready (hazard or backpressure). It saturates at all-ones.
- reset: pend=0, out_valid=0, out_A=0, out_B=0, out_DA=0, out_RW=0, stall_cycles=0.
- Reset mid-operation drops any pending output and all scoreboard state. in_ready during reset follows the combinational rules against the cleared state.
- Writes to R0 never set pend; R0 data comes straight from the file.

Decomposition:
- Shared package risc_pkg holds DATA_W/ADDR_W defaults and the NREG constant. It also holds R0 index = 0.
- One natural sub-module: risc_scoreboard, containing the pend vector, set/clear logic and the pending lookups for three addresses.
- Forwarding muxes and the output register stay in the top.

Test Plan:
- Reset, then issue AA=3, BA=4, DA=5, RW=1, file holding R3=3, R4=4 -> next cycle out_valid=1, out_A=3, out_B=4, out_DA=5; pend[5]=1.
- Next instruction reads AA=5 while no writeback occurs -> in_ready=0 and stall_cycles increments each cycle. Then wb_RW=1, wb_DA=5, wb_D_Data=0xDEADBEEF -> issue that cycle with out_A=0xDEADBEEF next cycle, and pend[5] clears.
- Instruction with DA=5 while pend[5]=1 (WAW) -> stalled. Same-cycle wb of R5 -> issues, and pend[5] stays 1 (set wins).
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0, stall_cycles += 3 with a valid instruction waiting.
- DA=0, RW=1 issued -> pend unchanged. Later AA=0 -> no stall, out_A = rf_A_Data.
- Assert reset with pend[7]=1 and out_valid=1 -> next cycle all pend=0, out_valid=0, stall_cycles=0. A read of R7 then issues without stall.
